axis_bram_adapter_v2_0_cntl: RTL and testbench

//  Control path between an AXI-Stream port and a wide BRAM of WORDS_PER_LINE words per line.

---
 rtl/axis_bram_adapter_v2_0_cntl.sv | 116 +++++++++++
 tb/tb_axis_bram_adapter_v2_0_cntl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_adapter_v2_0_cntl.sv
// axis_bram_adapter_v2_0_cntl: AXIS <-> wide BRAM line pack/unpack control; optional tlast flush via AXIS_BRAM_CNTL_TLAST_FLUSH_EN
module axis_bram_adapter_v2_0_cntl #(
  parameter int BRAM_ADDR_LENGTH = 12,
  parameter int WORDS_PER_LINE = 36,
  localparam int CNT_BITS = $clog2(WORDS_PER_LINE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        rw,
  input  logic [BRAM_ADDR_LENGTH-1:0] bram_start_index,
  input  logic [BRAM_ADDR_LENGTH-1:0] bram_bound_index,
  output logic                        busy,
  output logic                        done,
  output logic                        truncated,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        pack_load,
  output logic [CNT_BITS-1:0]         pack_sel,
  output logic [CNT_BITS-1:0]         unpack_sel,
  output logic                        line_capture,
  output logic                        bram_en,
  output logic                        bram_wen,
  output logic [BRAM_ADDR_LENGTH-1:0] bram_index
);
`ifdef AXIS_BRAM_CNTL_TLAST_FLUSH_EN
  localparam logic FLUSH_EN = 1'b1;
`else
  localparam logic FLUSH_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, WR, WR_LAST, RD_REQ, RD_WAIT, RD, DONE} state_t;
  state_t state;
  logic [CNT_BITS-1:0] cnt;
  logic [BRAM_ADDR_LENGTH-1:0] bound;
  logic last_slot, at_bound, flush, short_line;
  assign s_axis_tready = state == WR;
  assign m_axis_tvalid = state == RD;
  assign busy = state != IDLE && state != DONE;
  assign pack_load = s_axis_tvalid && s_axis_tready;
  assign pack_sel = cnt;
  assign unpack_sel = cnt;
  assign last_slot = cnt == CNT_BITS'(WORDS_PER_LINE - 1);
  assign at_bound = bram_index == bound;
  assign flush = FLUSH_EN && s_axis_tlast;
  assign m_axis_tlast = m_axis_tvalid && last_slot && at_bound;
  // Transfer sequencing; BRAM strobes, done and truncated are registered pulses.
  // The line address advances on the edge after each write cycle so the next line packs without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bound <= '0;
      bram_index <= '0;
      bram_en <= 1'b0;
      bram_wen <= 1'b0;
      line_capture <= 1'b0;
      done <= 1'b0;
      truncated <= 1'b0;
      short_line <= 1'b0;
    end else begin
      bram_en <= 1'b0;
      bram_wen <= 1'b0;
      line_capture <= 1'b0;
      done <= 1'b0;
      truncated <= 1'b0;
      if (bram_wen) bram_index <= bram_index + BRAM_ADDR_LENGTH'(1);
      case (state)
        IDLE: if (start) begin
          bound <= bram_bound_index;
          bram_index <= bram_start_index;
          cnt <= '0;
          bram_en <= !rw;
          state <= rw ? WR : RD_REQ;
        end
        WR: if (pack_load) begin
          cnt <= (last_slot || flush) ? '0 : cnt + CNT_BITS'(1);
          if (last_slot || flush) begin
            bram_en <= 1'b1;
            bram_wen <= 1'b1;
          end
          if ((last_slot && at_bound) || flush) begin
            short_line <= flush && !(last_slot && at_bound);
            state <= WR_LAST;
          end
        end
        WR_LAST: begin
          done <= 1'b1;
          truncated <= short_line;
          state <= DONE;
        end
        RD_REQ: begin
          line_capture <= 1'b1;
          state <= RD_WAIT;
        end
        RD_WAIT: state <= RD;
        RD: if (m_axis_tready) begin
          cnt <= last_slot ? '0 : cnt + CNT_BITS'(1);
          if (last_slot && at_bound) begin
            done <= 1'b1;
            state <= DONE;
          end else if (last_slot) begin
            bram_index <= bram_index + BRAM_ADDR_LENGTH'(1);
            bram_en <= 1'b1;
            state <= RD_REQ;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_bram_adapter_v2_0_cntl.sv
// tb_axis_bram_adapter_v2_0_cntl: scoreboard bench for the AXIS/BRAM control path (AW=3, W=4)
module tb_axis_bram_adapter_v2_0_cntl;
  localparam int AW = 3;
  localparam int W = 4;
  localparam int C = 2;
`ifdef AXIS_BRAM_CNTL_TLAST_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif
  logic clk = 0, rst = 0, start = 0, rw = 0;
  logic [AW-1:0] bram_start_index = '0, bram_bound_index = '0;
  logic busy, done, truncated, s_axis_tready, m_axis_tvalid, m_axis_tlast;
  logic s_axis_tvalid = 0, s_axis_tlast = 0, m_axis_tready = 0;
  logic pack_load, line_capture, bram_en, bram_wen;
  logic [C-1:0] pack_sel, unpack_sel;
  logic [AW-1:0] bram_index;
  int passed = 0, total = 0;
  int exp_addr[$];
  int exp_sel[$];
  int exp_last[$];

  axis_bram_adapter_v2_0_cntl #(.BRAM_ADDR_LENGTH(AW), .WORDS_PER_LINE(W)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw),
    .bram_start_index(bram_start_index), .bram_bound_index(bram_bound_index),
    .busy(busy), .done(done), .truncated(truncated),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .pack_load(pack_load), .pack_sel(pack_sel), .unpack_sel(unpack_sel),
    .line_capture(line_capture), .bram_en(bram_en), .bram_wen(bram_wen), .bram_index(bram_index)
  );

  always #5 clk = ~clk;

  task automatic start_xfer(input logic dir, input int s, input int b);
    @(negedge clk);
    start = 1;
    rw = dir;
    bram_start_index = AW'(s);
    bram_bound_index = AW'(b);
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic do_write(input int s, input int b, input int n, input int tl, input logic trunc);
    int sent = 0, cyc = 0, last_cyc = -10;
    logic fin = 0;
    exp_sel.delete();
    exp_addr.delete();
    for (int i = 0; i < n; i++) begin
      exp_sel.push_back(i % W);
      if (i % W == W - 1 || (FLUSH && i == tl - 1)) exp_addr.push_back((s + i / W) % (1 << AW));
    end
    start_xfer(1, s, b);
    while (!fin && cyc < 200) begin
      @(negedge clk);
      s_axis_tvalid = sent < n;
      s_axis_tlast = sent == tl - 1;
      #1;
      if (s_axis_tvalid && s_axis_tready) begin
        total++;
        if (pack_load !== 1'b1 || pack_sel !== C'(exp_sel[0]))
          $display("FAIL wr_beat%0d: load=%b sel=%0d, want load=1 sel=%0d", sent, pack_load, pack_sel, exp_sel[0]);
        else passed++;
        void'(exp_sel.pop_front());
        sent++;
        last_cyc = cyc;
      end
      if (sent == n && cyc == last_cyc + 1) begin
        total++;
        if (s_axis_tready !== 1'b0) $display("FAIL wr_tready_after_last: got %b want 0", s_axis_tready);
        else passed++;
      end
      if (bram_en) begin
        total++;
        if (exp_addr.size() == 0 || bram_wen !== 1'b1 || bram_index !== AW'(exp_addr[0]))
          $display("FAIL wr_bram: wen=%b idx=%0d pending=%0d, want wen=1 idx=%0d", bram_wen, bram_index,
                   exp_addr.size(), exp_addr.size() ? exp_addr[0] : -1);
        else passed++;
        if (exp_addr.size() != 0) void'(exp_addr.pop_front());
      end
      if (done) begin
        fin = 1;
        total++;
        if (truncated !== trunc || sent != n || exp_addr.size() != 0 || cyc - last_cyc != 2)
          $display("FAIL wr_done: trunc=%b beats=%0d left_writes=%0d lat=%0d, want trunc=%b beats=%0d left_writes=0 lat=2",
                   truncated, sent, exp_addr.size(), cyc - last_cyc, trunc, n);
        else passed++;
      end
      cyc++;
    end
    if (!fin) begin
      total++;
      $display("FAIL wr_timeout: done not seen, want done within 200 cycles");
    end
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
    @(negedge clk);
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL wr_after_done: done=%b busy=%b, want 0 0", done, busy);
    else passed++;
  endtask

  task automatic do_read(input int s, input int b, input int nl, input logic stall, input logic poke);
    int cyc = 0, dones = 0;
    logic fin = 0, pv = 0, pe = 0;
    logic [C-1:0] ps = '0;
    exp_addr.delete();
    exp_sel.delete();
    exp_last.delete();
    for (int l = 0; l < nl; l++) begin
      exp_addr.push_back((s + l) % (1 << AW));
      for (int k = 0; k < W; k++) begin
        exp_sel.push_back(k);
        exp_last.push_back((l == nl - 1 && k == W - 1) ? 1 : 0);
      end
    end
    start_xfer(0, s, b);
    while (!fin && cyc < 300) begin
      @(negedge clk);
      m_axis_tready = stall ? ((cyc % 2) == 0) : 1'b1;
      if (poke) begin
        start = cyc >= 2 && cyc < 6;
        rw = cyc[0];
        bram_start_index = AW'(cyc);
        bram_bound_index = AW'(cyc + 3);
      end
      #1;
      if (bram_en) begin
        total++;
        if (exp_addr.size() == 0 || bram_wen !== 1'b0 || bram_index !== AW'(exp_addr[0]))
          $display("FAIL rd_bram: wen=%b idx=%0d pending=%0d, want wen=0 idx=%0d", bram_wen, bram_index,
                   exp_addr.size(), exp_addr.size() ? exp_addr[0] : -1);
        else passed++;
        if (exp_addr.size() != 0) void'(exp_addr.pop_front());
      end
      if (pe) begin
        total++;
        if (line_capture !== 1'b1) $display("FAIL rd_capture: got %b want 1", line_capture);
        else passed++;
      end
      if (pv) begin
        total++;
        if (m_axis_tvalid !== 1'b1 || unpack_sel !== ps)
          $display("FAIL rd_stall_hold: valid=%b sel=%0d, want valid=1 sel=%0d", m_axis_tvalid, unpack_sel, ps);
        else passed++;
      end
      if (m_axis_tvalid) begin
        total++;
        if (exp_sel.size() == 0 || unpack_sel !== C'(exp_sel[0]) || m_axis_tlast !== exp_last[0][0])
          $display("FAIL rd_beat: sel=%0d last=%b, want sel=%0d last=%0d", unpack_sel, m_axis_tlast,
                   exp_sel.size() ? exp_sel[0] : -1, exp_last.size() ? exp_last[0] : -1);
        else passed++;
        if (m_axis_tready && exp_sel.size() != 0) begin
          void'(exp_sel.pop_front());
          void'(exp_last.pop_front());
        end
      end
      pv = m_axis_tvalid && !m_axis_tready;
      ps = unpack_sel;
      pe = bram_en;
      if (done) begin
        fin = 1;
        dones++;
        total++;
        if (exp_sel.size() != 0 || exp_addr.size() != 0 || truncated !== 1'b0)
          $display("FAIL rd_done: beats_left=%0d reads_left=%0d trunc=%b, want 0 0 0", exp_sel.size(), exp_addr.size(), truncated);
        else passed++;
      end
      cyc++;
    end
    if (!fin) begin
      total++;
      $display("FAIL rd_timeout: done not seen, want done within 300 cycles");
    end
    start = 0;
    rw = 0;
    m_axis_tready = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (done) dones++;
      if (busy) dones += 10;
    end
    total++;
    if (dones != 1) $display("FAIL rd_single_done: done/busy score=%0d, want 1", dones);
    else passed++;
  endtask

  task automatic test_reset;
    #2 rst = 1;
    #1;
    total++;
    if ({busy, done, truncated, s_axis_tready, m_axis_tvalid, m_axis_tlast, pack_load, line_capture,
         bram_en, bram_wen, pack_sel, unpack_sel, bram_index} !== '0)
      $display("FAIL reset_outputs: busy=%b en=%b idx=%0d, want all 0", busy, bram_en, bram_index);
    else passed++;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_write;
    do_write(2, 3, 8, 0, 1'b0);
  endtask

  task automatic test_read_stall;
    do_read(5, 6, 2, 1'b1, 1'b0);
  endtask

  task automatic test_read_wrap;
    do_read(7, 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset;
    start_xfer(1, 2, 3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_axis_tvalid = 1;
    end
    @(negedge clk);
    #2 rst = 1;
    #1;
    total++;
    if ({busy, done, truncated, s_axis_tready, m_axis_tvalid, m_axis_tlast, pack_load, line_capture,
         bram_en, bram_wen, pack_sel, unpack_sel, bram_index} !== '0)
      $display("FAIL async_reset: busy=%b load=%b sel=%0d idx=%0d, want all 0", busy, pack_load, pack_sel, bram_index);
    else passed++;
    @(negedge clk);
    rst = 0;
    s_axis_tvalid = 0;
    do_write(2, 3, 8, 0, 1'b0);
  endtask

  task automatic test_ignore_start;
    do_read(1, 1, 1, 1'b1, 1'b1);
  endtask

  task automatic test_flush;
    if (FLUSH) do_write(0, 3, 6, 6, 1'b1);
    else do_write(0, 3, 16, 6, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_read_wrap();
    test_async_reset();
    test_ignore_start();
    test_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
